// File: rtl/bus_arbiter_rr.sv
// Parametrised round-robin bus arbiter with active-low request/grant and bounded owner tenure.
// Optional feature: define BUS_ARB_LOCK_EN to add the lock_ port (locked owners are never preempted).
module bus_arbiter_rr #(
  parameter int NUM_MASTERS = 4,
  parameter int OWNER_W     = 2,
  parameter int MAX_TENURE  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] req_,
  output logic [NUM_MASTERS-1:0] grnt_,
  output logic [OWNER_W-1:0]     owner,
  output logic                   preempt
`ifdef BUS_ARB_LOCK_EN
  ,
  input  logic [NUM_MASTERS-1:0] lock_
`endif
);

  localparam int TEN_W = $clog2(MAX_TENURE) + 1;
  localparam logic [TEN_W-1:0] TEN_SAT  = '1;
  localparam logic [TEN_W-1:0] TEN_LAST = TEN_W'((MAX_TENURE > 0) ? MAX_TENURE - 1 : 0);

  logic [NUM_MASTERS-1:0] lock_act;
`ifdef BUS_ARB_LOCK_EN
  assign lock_act = ~lock_;
`else
  assign lock_act = '0;
`endif

  logic [TEN_W-1:0]   tenure;
  logic               owner_valid;
  logic               owner_req;
  logic               owner_locked;
  logic               other_req;
  logic               found;
  logic [OWNER_W-1:0] next_owner;
  logic [OWNER_W-1:0] owner_d;
  logic [TEN_W-1:0]   tenure_d;
  logic               preempt_d;

  // Classify the current owner against the request and lock vectors.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    owner_valid  = 1'b0;
    owner_req    = 1'b0;
    owner_locked = 1'b0;
    other_req    = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (owner == OWNER_W'(i)) begin
        owner_valid  = 1'b1;
        owner_req    = ~req_[i];
        owner_locked = ~req_[i] & lock_act[i];
      end else if (!req_[i]) begin
        other_req = 1'b1;
      end
    end
  end

  // First requester after the owner, wrapping modulo NUM_MASTERS; owner itself is excluded.
  always_comb begin
    int cand;
    cand       = 0;
    found      = 1'b0;
    next_owner = owner;
    for (int k = 1; k < NUM_MASTERS; k++) begin
      cand = int'(owner) + k;
      if (cand >= NUM_MASTERS) cand = cand - NUM_MASTERS;
      if (!found && cand < NUM_MASTERS && !req_[OWNER_W'(cand)]) begin
        found      = 1'b1;
        next_owner = OWNER_W'(cand);
      end
    end
  end

  always_comb begin
    owner_d   = owner;
    tenure_d  = '0;
    preempt_d = 1'b0;
    if (!owner_valid) begin
      owner_d = '0;
    end else if (owner_req && other_req && !owner_locked) begin
      if (MAX_TENURE > 0 && tenure == TEN_LAST) begin
        owner_d   = next_owner;
        preempt_d = 1'b1;
      end else if (tenure != TEN_SAT) begin
        tenure_d = tenure + 1'b1;
      end else begin
        tenure_d = tenure;
      end
    end else if (!owner_req && other_req && found) begin
      owner_d = next_owner;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments so all flops update from pre-edge values.
    if (!reset) begin
      owner   <= '0;
      tenure  <= '0;
      preempt <= 1'b0;
    end else begin
      owner   <= owner_d;
      tenure  <= tenure_d;
      preempt <= preempt_d;
    end
  end

  // Grant is a pure decode of the registered owner: exactly one low bit, never a gap.
  always_comb begin
    grnt_ = '1;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      grnt_[i] = (owner != OWNER_W'(i));
    end
  end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Self-checking bench for bus_arbiter_rr: a 4-master and a 3-master instance driven by directed
// scenarios and random traffic, compared every cycle against a queue-based round-robin model.
module tb_bus_arbiter_rr;

`ifdef BUS_ARB_LOCK_EN
  localparam bit LOCK_ON = 1'b1;
`else
  localparam bit LOCK_ON = 1'b0;
`endif

  localparam int NS [2] = '{4, 3};
  localparam int MT [2] = '{4, 3};

  logic       clk;
  logic       reset;
  logic [3:0] rq;
  logic [3:0] lk;

  logic [3:0] gr4;
  logic [1:0] own4;
  logic       pre4;
  logic [2:0] gr3;
  logic [1:0] own3;
  logic       pre3;

  bus_arbiter_rr #(.NUM_MASTERS(4), .OWNER_W(2), .MAX_TENURE(4)) u_dut4 (
    .clk     (clk),
    .reset   (reset),
    .req_    (rq),
    .grnt_   (gr4),
    .owner   (own4),
    .preempt (pre4)
`ifdef BUS_ARB_LOCK_EN
    ,
    .lock_   (lk)
`endif
  );

  bus_arbiter_rr #(.NUM_MASTERS(3), .OWNER_W(2), .MAX_TENURE(3)) u_dut3 (
    .clk     (clk),
    .reset   (reset),
    .req_    (rq[2:0]),
    .grnt_   (gr3),
    .owner   (own3),
    .preempt (pre3)
`ifdef BUS_ARB_LOCK_EN
    ,
    .lock_   (lk[2:0])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  int m_own [2];
  int m_ten [2];
  bit m_pre [2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_grant(input int n, input int o);
    logic [31:0] g;
    g = '0;
    for (int j = 0; j < n; j++) g[j] = (j != o);
    return g;
  endfunction

  // Round-robin rules: list waiting masters in rotation order after the owner; the head is next.
  task automatic model_step(input int d, input logic rst, input logic [3:0] r, input logic [3:0] l);
    int  n;
    int  waiting [$];
    bit  own_req;
    bit  locked;
    n = NS[d];
    m_pre[d] = 1'b0;
    if (!rst) begin
      m_own[d] = 0;
      m_ten[d] = 0;
      return;
    end
    for (int k = 1; k < n; k++) begin
      if (!r[(m_own[d] + k) % n]) waiting.push_back((m_own[d] + k) % n);
    end
    own_req = !r[m_own[d]];
    locked  = LOCK_ON && own_req && !l[m_own[d]];
    if (waiting.size() == 0) begin
      m_ten[d] = 0;
    end else if (!own_req) begin
      m_own[d] = waiting[0];
      m_ten[d] = 0;
    end else if (locked) begin
      m_ten[d] = 0;
    end else if (m_ten[d] == MT[d] - 1) begin
      m_own[d] = waiting[0];
      m_ten[d] = 0;
      m_pre[d] = 1'b1;
    end else begin
      m_ten[d] = m_ten[d] + 1;
    end
  endtask

  task automatic step(input logic [3:0] r, input logic [3:0] l, input logic rst);
    rq    = r;
    lk    = l;
    reset = rst;
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_step(d, rst, r, l);
    #1;
    check("owner4",   32'(own4), 32'(m_own[0]));
    check("grant4",   32'(gr4),  exp_grant(4, m_own[0]));
    check("preempt4", 32'(pre4), 32'(m_pre[0]));
    check("owner3",   32'(own3), 32'(m_own[1]));
    check("grant3",   32'(gr3),  exp_grant(3, m_own[1]));
    check("preempt3", 32'(pre3), 32'(m_pre[1]));
  endtask

  initial begin
    logic [3:0] r;
    logic [3:0] l;
    logic       rs;
    rq    = 4'b1111;
    lk    = 4'b1111;
    reset = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m_own[d] = 0;
      m_ten[d] = 0;
      m_pre[d] = 1'b0;
    end

    // Reset, then idle: bus parks on master 0.
    step(4'b1111, 4'b1111, 1'b0);
    step(4'b1111, 4'b1111, 1'b0);
    check("rst_grant4", 32'(gr4), 32'h0000_000e);
    step(4'b1111, 4'b1111, 1'b1);
    step(4'b1111, 4'b1111, 1'b1);

    // m1 and m3 request, then m1 drops.
    step(4'b0101, 4'b1111, 1'b1);
    check("hand_to_m1", 32'(own4), 32'd1);
    step(4'b0111, 4'b1111, 1'b1);
    check("hand_to_m3", 32'(own4), 32'd3);

    // Everyone requests: forced rotation every MAX_TENURE cycles.
    step(4'b1111, 4'b1111, 1'b0);
    for (int i = 0; i < 14; i++) step(4'b0000, 4'b1111, 1'b1);

    // Wrap past the top index on both sizes.
    step(4'b0111, 4'b1111, 1'b1);
    step(4'b1100, 4'b1111, 1'b1);
    step(4'b1011, 4'b1111, 1'b1);
    step(4'b1110, 4'b1111, 1'b1);

    // Reset in the middle of contended ownership.
    step(4'b1011, 4'b1111, 1'b1);
    step(4'b0000, 4'b1111, 1'b1);
    step(4'b0000, 4'b1111, 1'b0);
    check("midrst_owner4", 32'(own4), 32'd0);

    // Locked owner holds the bus under full contention.
    step(4'b1101, 4'b1111, 1'b1);
    for (int i = 0; i < 10; i++) step(4'b0000, 4'b1101, 1'b1);

    // Random traffic with heavy-contention bursts and occasional resets.
    for (int i = 0; i < 600; i++) begin
      rs = ($urandom_range(0, 59) != 0);
      case ($urandom_range(0, 3))
        0:       r = 4'b0000;
        1:       r = 4'($urandom) | 4'($urandom);
        default: r = 4'($urandom);
      endcase
      l = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b1111;
      step(r, l, rs);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
